stream_packer: RTL and testbench

// - Upstream width-up stage: packs Ratio narrow valid/ready beats into one wide beat for the

---
 rtl/stream_packer.sv | 130 +++++++++++++
 tb/tb_stream_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// Width-up packer: gathers Ratio narrow valid/ready beats into one wide word, with early flush on last.
// Optional feature macro: STREAM_PACKER_COUNT_EN adds data_out_count_o (valid beats per output word).
module stream_packer #(
    parameter int InWidth = 8,
    parameter int Ratio   = 4
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [InWidth-1:0]         data_in_i,
    input  logic                       data_in_last_i,
    input  logic                       data_in_valid_i,
    output logic                       data_in_ready_o,
    output logic [InWidth*Ratio-1:0]   data_out_o,
    output logic                       data_out_last_o,
    output logic                       data_out_valid_o,
`ifdef STREAM_PACKER_COUNT_EN
    output logic [$clog2(Ratio+1)-1:0] data_out_count_o,
`endif
    input  logic                       data_out_ready_i
);

    localparam int OutWidth = InWidth * Ratio;
    localparam int IdxW     = $clog2(Ratio);
    localparam int CntW     = $clog2(Ratio + 1);

    // Word as it stands once the beat at idx lands; slices above idx are zero.
    function automatic logic [OutWidth-1:0] merge_beat(
        input logic [OutWidth-1:0] acc,
        input logic [IdxW-1:0]     idx,
        input logic [InWidth-1:0]  beat
    );
        logic [OutWidth-1:0] word;
        word = {OutWidth{1'b0}};
        for (int j = 0; j < Ratio; j++) begin
            if (IdxW'(j) < idx) begin
                word[j*InWidth +: InWidth] = acc[j*InWidth +: InWidth];
            end else if (IdxW'(j) == idx) begin
                word[j*InWidth +: InWidth] = beat;
            end else begin
                word[j*InWidth +: InWidth] = {InWidth{1'b0}};
            end
        end
        return word;
    endfunction

    logic [OutWidth-1:0] acc_q, acc_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [OutWidth-1:0] out_q, out_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic [CntW-1:0]     count_q, count_d;

    logic                ready_s;
    logic                accept_s;
    logic                complete_s;
    logic                drain_s;
    logic [OutWidth-1:0] merged_s;

    assign ready_s    = !valid_q || data_out_ready_i;
    assign accept_s   = data_in_valid_i && ready_s;
    assign complete_s = accept_s && ((idx_q == IdxW'(Ratio - 1)) || data_in_last_i);
    assign drain_s    = valid_q && data_out_ready_i;
    assign merged_s   = merge_beat(acc_q, idx_q, data_in_i);

    assign data_in_ready_o  = ready_s;
    assign data_out_o       = out_q;
    assign data_out_last_o  = last_q;
    assign data_out_valid_o = valid_q;

    // Accumulator and beat index: fill on accept, clear when a word completes.
    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        if (complete_s) begin
            acc_d = {OutWidth{1'b0}};
            idx_d = {IdxW{1'b0}};
        end else if (accept_s) begin
            acc_d = merged_s;
            idx_d = idx_q + IdxW'(1);
        end else begin
            acc_d = acc_q;
            idx_d = idx_q;
        end
    end

    // Output register: a completing word wins over a drain, so words can go back-to-back.
    always_comb begin
        out_d   = out_q;
        last_d  = last_q;
        valid_d = valid_q;
        count_d = count_q;
        if (complete_s) begin
            out_d   = merged_s;
            last_d  = data_in_last_i;
            valid_d = 1'b1;
            count_d = CntW'(idx_q) + CntW'(1);
        end else if (drain_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; reset discards both the partial word and any pending output.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            acc_q   <= {OutWidth{1'b0}};
            idx_q   <= {IdxW{1'b0}};
            out_q   <= {OutWidth{1'b0}};
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= {CntW{1'b0}};
        end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

`ifdef STREAM_PACKER_COUNT_EN
    assign data_out_count_o = count_q;
`else
    logic unused_count_s;
    assign unused_count_s = ^count_q;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer (InWidth=8, Ratio=4): queue-based reference model checked every
// cycle, plus literal expectations on the delivered words.
module tb_stream_packer;

    logic        clk;
    logic        srst;
    logic [7:0]  din;
    logic        lst;
    logic        vld;
    logic        rdy;
    logic [31:0] dout;
    logic        dlast;
    logic        dvalid;
    logic        out_rdy;
`ifdef STREAM_PACKER_COUNT_EN
    logic [2:0]  dcount;
`endif

    stream_packer #(.InWidth(8), .Ratio(4)) dut (
        .clk_i           (clk),
        .srst_i          (srst),
        .data_in_i       (din),
        .data_in_last_i  (lst),
        .data_in_valid_i (vld),
        .data_in_ready_o (rdy),
        .data_out_o      (dout),
        .data_out_last_o (dlast),
        .data_out_valid_o(dvalid),
`ifdef STREAM_PACKER_COUNT_EN
        .data_out_count_o(dcount),
`endif
        .data_out_ready_i(out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending beats in a queue, one expected output register.
    logic [7:0]  pend[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = 32'h0;
    logic        m_last  = 1'b0;
    int          m_count = 0;
    bit          m_live  = 1'b0;
    int          cyc     = 0;

    always @(posedge clk) begin
        bit acc;
        cyc++;
        if (srst) begin
            pend.delete();
            m_valid = 1'b0;
            m_data  = 32'h0;
            m_last  = 1'b0;
            m_count = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            acc = vld && (!m_valid || out_rdy);
            if (acc) pend.push_back(din);
            if (acc && (pend.size() == 4 || lst)) begin
                m_data = 32'h0;
                foreach (pend[i]) m_data = m_data | (32'(pend[i]) << (8 * i));
                m_last  = lst;
                m_count = pend.size();
                m_valid = 1'b1;
                pend.delete();
            end else if (m_valid && out_rdy) begin
                m_valid = 1'b0;
            end
        end
    end

    // Delivered words, logged when consumed.
    logic [31:0] got[$];
    logic        got_last[$];
    int          got_cyc[$];

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", 64'(rdy), 64'(!m_valid || out_rdy));
            check("out_valid", 64'(dvalid), 64'(m_valid));
            if (m_valid) begin
                check("out_data", 64'(dout), 64'(m_data));
                check("out_last", 64'(dlast), 64'(m_last));
`ifdef STREAM_PACKER_COUNT_EN
                check("out_count", 64'(dcount), 64'(m_count));
`endif
            end
            if (dvalid && out_rdy) begin
                got.push_back(dout);
                got_last.push_back(dlast);
                got_cyc.push_back(cyc);
            end
        end
    end

    int waits = 0;

    task automatic beat(input logic [7:0] d, input logic l);
        bit ok;
        int n;
        n = 0;
        vld = 1'b1; din = d; lst = l;
        do begin
            @(negedge clk);
            ok = rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        waits += n;
        if (!ok) check("beat_timeout", 64'(n), 64'(0));
    endtask

    task automatic idle(input int n);
        vld = 1'b0; lst = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        got.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    initial begin
        srst = 1'b1; vld = 1'b0; din = 8'h00; lst = 1'b0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check("rst_data", 64'(dout), 64'h0);
        check("rst_valid", 64'(dvalid), 64'h0);
        check("rst_last", 64'(dlast), 64'h0);
        check("rst_ready", 64'(rdy), 64'h1);
        @(posedge clk); #1;

        // Full word
        clear_log();
        beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
        idle(4);
        check("full_n", 64'(got.size()), 64'd1);
        if (got.size() >= 1) begin
            check("full_word", 64'(got[0]), 64'h44332211);
            check("full_last", 64'(got_last[0]), 64'h0);
        end

        // Partial flush
        clear_log();
        beat(8'hAA, 1'b0); beat(8'hBB, 1'b1);
`ifdef STREAM_PACKER_COUNT_EN
        @(negedge clk);
        check("part_count", 64'(dcount), 64'd2);
        @(posedge clk); #1;
`endif
        idle(3);
        check("part_n", 64'(got.size()), 64'd1);
        if (got.size() >= 1) begin
            check("part_word", 64'(got[0]), 64'h0000BBAA);
            check("part_last", 64'(got_last[0]), 64'h1);
        end

        // Last on the fourth beat still gives a full word
        clear_log();
        beat(8'hC1, 1'b0); beat(8'hC2, 1'b0); beat(8'hC3, 1'b0); beat(8'hC4, 1'b1);
        idle(3);
        if (got.size() >= 1) begin
            check("full_last_word", 64'(got[0]), 64'hC4C3C2C1);
            check("full_last_flag", 64'(got_last[0]), 64'h1);
        end else check("full_last_n", 64'(got.size()), 64'd1);

        // Backpressure
        clear_log();
        beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
        out_rdy = 1'b0;
        fork
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("bp_hold_word", 64'(dout), 64'h04030201);
                check("bp_hold_valid", 64'(dvalid), 64'h1);
                check("bp_in_ready", 64'(rdy), 64'h0);
                @(posedge clk); #1;
                out_rdy = 1'b1;
            end
        join_none
        beat(8'h05, 1'b0); beat(8'h06, 1'b0); beat(8'h07, 1'b0); beat(8'h08, 1'b0);
        idle(3);
        check("bp_n", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            check("bp_word0", 64'(got[0]), 64'h04030201);
            check("bp_word1", 64'(got[1]), 64'h08070605);
        end

        // Back-to-back
        clear_log();
        waits = 0;
        for (int i = 0; i < 16; i++) beat(8'h10 + 8'(i), 1'b0);
        idle(3);
        check("b2b_waits", 64'(waits), 64'd16);
        check("b2b_n", 64'(got.size()), 64'd4);
        if (got.size() >= 4) begin
            check("b2b_word0", 64'(got[0]), 64'h13121110);
            check("b2b_word3", 64'(got[3]), 64'h1F1E1D1C);
            for (int k = 0; k < 3; k++) check("b2b_spacing", 64'(got_cyc[k+1] - got_cyc[k]), 64'd4);
        end

        // Reset mid-word
        clear_log();
        beat(8'h11, 1'b0); beat(8'h22, 1'b0);
        vld = 1'b0;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        check("rst_mid_valid", 64'(dvalid), 64'h0);
        beat(8'h33, 1'b0); beat(8'h44, 1'b0); beat(8'h55, 1'b0); beat(8'h66, 1'b0);
        idle(3);
        check("rst_mid_n", 64'(got.size()), 64'd1);
        if (got.size() >= 1) check("rst_mid_word", 64'(got[0]), 64'h66554433);

        // Reset wins over a handshake on the same edge
        clear_log();
        beat(8'h71, 1'b0); beat(8'h72, 1'b0); beat(8'h73, 1'b0);
        vld = 1'b1; din = 8'h74; srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        idle(3);
        check("rst_prio_n", 64'(got.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
